// File: rtl/operand_mux_pipe_pkg.sv
// operand_pkg: shared definitions for the operand multiplexer pipeline.
//   LEGACY_NUM_SRC : source count for which the bit-reversed select map applies
//   occ_e          : occupancy of the 2-entry output FIFO
//   entry_w()      : width of one buffered entry {op_a, op_b, sel_err}
//   idx_map()      : select field -> source index
package operand_pkg;

    localparam int unsigned LEGACY_NUM_SRC = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic int unsigned entry_w(input int unsigned width);
        return 2 * width + 1;
    endfunction

    // Legacy decode swaps the two select bits: 00->0, 10->1, 01->2, 11->3.
    function automatic int unsigned idx_map(input int unsigned sel,
                                            input bit          legacy,
                                            input int unsigned num_src);
        if (legacy && num_src == LEGACY_NUM_SRC)
            return {30'd0, sel[0], sel[1]};
        return sel;
    endfunction

endpackage

// File: rtl/operand_mux_pipe_if.sv
// operand_mux_pipe_if: handshake and data bundle for operand_mux_pipe.
//   in_valid/in_ready   : upstream beat handshake
//   src_data            : NUM_SRC packed source words, source k at [k*WIDTH +: WIDTH]
//   sel_a/sel_b         : operand selects
//   flush               : drop all buffered beats
//   out_valid/out_ready : downstream beat handshake
//   op_a/op_b/sel_err   : head beat presented to the ALU
// Modports: slave = the mux pipeline, master = the stage driving it.
interface operand_mux_pipe_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         sel_a;
    logic [SEL_W-1:0]         sel_b;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         op_a;
    logic [WIDTH-1:0]         op_b;
    logic                     sel_err;

    modport slave (
        input  in_valid, src_data, sel_a, sel_b, flush, out_ready,
        output in_ready, out_valid, op_a, op_b, sel_err
    );

    modport master (
        output in_valid, src_data, sel_a, sel_b, flush, out_ready,
        input  in_ready, out_valid, op_a, op_b, sel_err
    );

endinterface

// File: rtl/operand_mux_pipe_fifo2.sv
// operand_fifo2: generic 2-entry registered FIFO.
//   clk, rst_n : clock, synchronous active-low reset (clears entries to zero)
//   push_i     : write din_i (caller only pushes while count_o < 2)
//   pop_i      : drop head (caller only pops while count_o != 0)
//   flush_i    : empty the FIFO; overrides push and pop
//   din_i      : write data
//   dout_o     : head entry, straight from a register
//   count_o    : occupancy 0..2
module operand_fifo2
    import operand_pkg::*;
#(
    parameter int unsigned DW = 65
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic [1:0]    count_o
);

    occ_e          occ_q, occ_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush_i) begin
            occ_d = OCC_EMPTY;
        end else if (push_i && pop_i && occ_q != OCC_EMPTY) begin
            // Occupancy unchanged; head advances, new beat lands behind it.
            if (occ_q == OCC_FULL) begin
                head_d = tail_q;
                tail_d = din_i;
            end else begin
                head_d = din_i;
            end
        end else if (push_i) begin
            if (occ_q == OCC_EMPTY) begin
                head_d = din_i;
                occ_d  = OCC_ONE;
            end else if (occ_q == OCC_ONE) begin
                tail_d = din_i;
                occ_d  = OCC_FULL;
            end
        end else if (pop_i) begin
            head_d = tail_q;
            occ_d  = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign dout_o  = head_q;
    assign count_o = occ_q;

endmodule

// File: rtl/operand_mux_pipe.sv
// operand_mux_pipe: selects operands A and B from NUM_SRC packed sources and
// buffers them in a 2-entry skid FIFO in front of the ALU input register.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : operand_mux_pipe_if slave (handshakes, sources, selects,
//                flush, selected operands and per-beat select error)
// Selection happens at push; the FIFO stores {op_a, op_b, sel_err}.
module operand_mux_pipe
    import operand_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned SEL_W      = $clog2(NUM_SRC),
    parameter bit          LEGACY_ENC = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_mux_pipe_if.slave    bus
);

    localparam int unsigned EW = entry_w(WIDTH);

    logic [SEL_W-1:0] sel_a, sel_b;
    int unsigned      idx_a, idx_b;
    logic             err_a, err_b;
    logic [WIDTH-1:0] mux_a, mux_b;
    logic [EW-1:0]    entry_in, entry_out;
    logic [1:0]       count;
    logic             push, pop;

    assign sel_a = bus.sel_a;
    assign sel_b = bus.sel_b;

    // An out-of-range index matches no source, so its operand stays zero.
    always_comb begin
        idx_a = idx_map(32'(sel_a), LEGACY_ENC, NUM_SRC);
        idx_b = idx_map(32'(sel_b), LEGACY_ENC, NUM_SRC);
        err_a = (idx_a >= NUM_SRC);
        err_b = (idx_b >= NUM_SRC);
        mux_a = '0;
        mux_b = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (idx_a == k) mux_a = bus.src_data[k*WIDTH +: WIDTH];
            if (idx_b == k) mux_b = bus.src_data[k*WIDTH +: WIDTH];
        end
    end

    assign entry_in = {mux_a, mux_b, err_a | err_b};

    // in_ready depends only on registered occupancy and reset, never on out_ready.
    assign bus.in_ready  = rst_n && (count < 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    operand_fifo2 #(
        .DW(EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.flush),
        .din_i   (entry_in),
        .dout_o  (entry_out),
        .count_o (count)
    );

    assign {bus.op_a, bus.op_b, bus.sel_err} = entry_out;

endmodule

// File: tb/tb_operand_mux_pipe.sv
module tb_operand_mux_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    operand_mux_pipe_if #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2)) b4 ();
    operand_mux_pipe_if #(.WIDTH(32), .NUM_SRC(5), .SEL_W(3)) b5 ();

    operand_mux_pipe #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2), .LEGACY_ENC(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave));
    operand_mux_pipe #(.WIDTH(32), .NUM_SRC(5), .SEL_W(3), .LEGACY_ENC(1'b0)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(b5.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference beat {op_a, op_b, sel_err} from the selection rules.
    function automatic logic [64:0] ref_beat(input logic [511:0] src, input int unsigned n,
                                             input bit legacy, input int unsigned sa,
                                             input int unsigned sb);
        int unsigned tab [4];
        int unsigned ia, ib;
        logic [31:0] a, b;
        tab = '{0, 2, 1, 3};
        ia = sa;
        ib = sb;
        if (legacy && n == 4) begin
            ia = tab[sa];
            ib = tab[sb];
        end
        a = (ia < n) ? src[ia*32 +: 32] : 32'd0;
        b = (ib < n) ? src[ib*32 +: 32] : 32'd0;
        return {a, b, (ia >= n) || (ib >= n)};
    endfunction

    // Queue model of each pipeline
    logic [64:0] q4[$];
    logic [64:0] q5[$];
    bit clean4 = 0, clean5 = 0, started = 0;

    always @(posedge clk) begin
        started <= 1;
        if (!rst_n) begin
            q4.delete();
            clean4 <= 1;
        end else if (b4.flush) begin
            q4.delete();
            clean4 <= 0;
        end else if (b4.in_valid && q4.size() < 2) begin
            if (q4.size() != 0 && b4.out_ready) void'(q4.pop_front());
            q4.push_back(ref_beat(512'(b4.src_data), 4, 1'b1, 32'(b4.sel_a), 32'(b4.sel_b)));
            clean4 <= 0;
        end else if (q4.size() != 0 && b4.out_ready) begin
            void'(q4.pop_front());
        end

        if (!rst_n) begin
            q5.delete();
            clean5 <= 1;
        end else if (b5.flush) begin
            q5.delete();
            clean5 <= 0;
        end else if (b5.in_valid && q5.size() < 2) begin
            if (q5.size() != 0 && b5.out_ready) void'(q5.pop_front());
            q5.push_back(ref_beat(512'(b5.src_data), 5, 1'b0, 32'(b5.sel_a), 32'(b5.sel_b)));
            clean5 <= 0;
        end else if (q5.size() != 0 && b5.out_ready) begin
            void'(q5.pop_front());
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m4_out_valid", 64'(b4.out_valid), 64'(q4.size() != 0));
            chk("m4_in_ready", 64'(b4.in_ready), 64'(rst_n && q4.size() < 2));
            if (q4.size() != 0) begin
                chk("m4_op_a", 64'(b4.op_a), 64'(q4[0][64:33]));
                chk("m4_op_b", 64'(b4.op_b), 64'(q4[0][32:1]));
                chk("m4_sel_err", 64'(b4.sel_err), 64'(q4[0][0]));
            end else if (clean4) begin
                chk("m4_rst_data", {31'd0, b4.op_a, b4.sel_err}, 64'd0);
                chk("m4_rst_op_b", 64'(b4.op_b), 64'd0);
            end
            chk("m5_out_valid", 64'(b5.out_valid), 64'(q5.size() != 0));
            chk("m5_in_ready", 64'(b5.in_ready), 64'(rst_n && q5.size() < 2));
            if (q5.size() != 0) begin
                chk("m5_op_a", 64'(b5.op_a), 64'(q5[0][64:33]));
                chk("m5_op_b", 64'(b5.op_b), 64'(q5[0][32:1]));
                chk("m5_sel_err", 64'(b5.sel_err), 64'(q5[0][0]));
            end else if (clean5) begin
                chk("m5_rst_data", {31'd0, b5.op_a, b5.sel_err}, 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src4(input logic [31:0] s0);
        b4.src_data = {32'h0D, 32'h0C, 32'h0B, s0};
    endtask

    initial begin
        b4.in_valid = 0; b4.sel_a = '0; b4.sel_b = '0; b4.flush = 0; b4.out_ready = 1;
        b5.in_valid = 0; b5.sel_a = '0; b5.sel_b = '0; b5.flush = 0; b5.out_ready = 1;
        set_src4(32'h0A);
        b5.src_data = {32'h54, 32'h53, 32'h52, 32'h51, 32'h50};

        // Reset
        step(); step();
        chk("rst_out_valid", 64'(b4.out_valid), 64'd0);
        chk("rst_op_a", 64'(b4.op_a), 64'd0);
        chk("rst_in_ready_low", 64'(b4.in_ready), 64'd0);
        rst_n = 1;
        step();
        chk("rel_in_ready", 64'(b4.in_ready), 64'd1);

        // Legacy select map
        b4.sel_a = 2'b10; b4.sel_b = 2'b01; b4.in_valid = 1;
        step();
        chk("leg_op_a", 64'(b4.op_a), 64'h0B);
        chk("leg_op_b", 64'(b4.op_b), 64'h0C);
        chk("leg_err", 64'(b4.sel_err), 64'd0);
        b4.sel_a = 2'b11; b4.sel_b = 2'b00;
        step();
        chk("leg2_op_a", 64'(b4.op_a), 64'h0D);
        chk("leg2_op_b", 64'(b4.op_b), 64'h0A);
        b4.in_valid = 0; b4.sel_a = '0; b4.sel_b = '0;
        step();

        // Out-of-range selects on NUM_SRC=5
        b5.sel_a = 3'd4; b5.sel_b = 3'd6; b5.in_valid = 1;
        step();
        chk("oor_op_a", 64'(b5.op_a), 64'h54);
        chk("oor_op_b", 64'(b5.op_b), 64'd0);
        chk("oor_err", 64'(b5.sel_err), 64'd1);
        b5.sel_a = 3'd1; b5.sel_b = 3'd2;
        step();
        chk("ok_err", 64'(b5.sel_err), 64'd0);
        chk("ok_op_a", 64'(b5.op_a), 64'h51);
        chk("ok_op_b", 64'(b5.op_b), 64'h52);
        b5.sel_a = 3'd5; b5.sel_b = 3'd7;
        step();
        chk("oor2_ops", {b5.op_a, b5.op_b}, 64'd0);
        chk("oor2_err", 64'(b5.sel_err), 64'd1);
        b5.in_valid = 0;
        step();

        // Backpressure
        b4.out_ready = 0; b4.in_valid = 1;
        set_src4(32'd1); step();
        set_src4(32'd2); step();
        chk("bp_full_in_ready", 64'(b4.in_ready), 64'd0);
        chk("bp_head1", 64'(b4.op_a), 64'd1);
        set_src4(32'd3); step(); step();
        chk("bp_hold_head", 64'(b4.op_a), 64'd1);
        b4.out_ready = 1;
        step();
        chk("bp_out2", 64'(b4.op_a), 64'd2);
        step();
        chk("bp_out3", 64'(b4.op_a), 64'd3);
        b4.in_valid = 0;
        step();
        chk("bp_drained", 64'(b4.out_valid), 64'd0);

        // Full throughput
        for (int i = 0; i < 10; i++) begin
            b4.in_valid = 1;
            set_src4(32'(100 + i));
            step();
            chk("tp_op_a", 64'(b4.op_a), 64'(100 + i));
            chk("tp_in_ready", 64'(b4.in_ready), 64'd1);
        end
        b4.in_valid = 0;
        step();
        chk("tp_drained", 64'(b4.out_valid), 64'd0);

        // Flush while full with input pending
        b4.out_ready = 0; b4.in_valid = 1;
        set_src4(32'h51); step();
        set_src4(32'h52); step();
        set_src4(32'h53); b4.flush = 1;
        step();
        chk("fl_out_valid", 64'(b4.out_valid), 64'd0);
        b4.flush = 0; b4.in_valid = 0;
        step();
        chk("fl_no_leak", 64'(b4.out_valid), 64'd0);

        // Flush with one entry, a pop and an accepted push in the same cycle
        b4.out_ready = 1; b4.in_valid = 1;
        set_src4(32'h61); step();
        set_src4(32'h62); b4.flush = 1;
        step();
        chk("fl2_out_valid", 64'(b4.out_valid), 64'd0);
        b4.flush = 0; b4.in_valid = 0;
        step();
        chk("fl2_no_leak", 64'(b4.out_valid), 64'd0);

        // Reset mid-stream with two entries
        b4.out_ready = 0; b4.in_valid = 1;
        set_src4(32'h71); step();
        set_src4(32'h72); step();
        set_src4(32'h73); rst_n = 0;
        #1;
        chk("mr_in_ready_low", 64'(b4.in_ready), 64'd0);
        step();
        chk("mr_out_valid", 64'(b4.out_valid), 64'd0);
        chk("mr_ops", {b4.op_a, b4.op_b}, 64'd0);
        chk("mr_err", 64'(b4.sel_err), 64'd0);
        rst_n = 1; b4.in_valid = 0;
        #1;
        chk("mr_in_ready_high", 64'(b4.in_ready), 64'd1);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
